// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    localparam int unsigned UART_DATA_W  = 8;
    localparam int unsigned UART_DIV_W   = 12;
    localparam int unsigned UART_MIN_DIV = 4;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;
    localparam logic STOP_ONE    = 1'b0;
    localparam logic STOP_TWO    = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP1,
        STOP2
    } rx_state_t;

    typedef struct packed {
        logic [UART_DATA_W-1:0] data;
        logic                   parity_err;
        logic                   frame_err;
    } rx_result_t;

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and frame config in, received byte and status out.
interface uart_rx_if #(
    parameter int unsigned DATA_W = uart_pkg::UART_DATA_W,
    parameter int unsigned DIV_W  = uart_pkg::UART_DIV_W
);
    logic              rx_in;
    logic              parity_sel;
    logic              stop_sel;
    logic [DIV_W-1:0]  baud_divisor;
    logic [DATA_W-1:0] data_out;
    logic              valid_out;
    logic              parity_err;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx_in, parity_sel, stop_sel, baud_divisor,
        input  data_out, valid_out, parity_err, frame_err, busy
    );

    modport slave (
        input  rx_in, parity_sel, stop_sel, baud_divisor,
        output data_out, valid_out, parity_err, frame_err, busy
    );
endinterface

// File: rtl/uart_rx_controller.sv
// Frame sequencer: start detect, bit timing, per-field sample strobes and frame-done pulse.
module uart_rx_controller
    import uart_pkg::*;
#(
    parameter int unsigned DIV_W = UART_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rx_s,
    input  logic             rx_d,
    input  logic             parity_sel,
    input  logic             stop_sel,
    input  logic [DIV_W-1:0] baud_divisor,
    output logic             parity_sel_q,
    output logic             busy,
    output logic             shift_en_c,
    output logic             parity_en_c,
    output logic             stop1_en_c,
    output logic             stop2_en_c,
    output logic             done_c
);

    localparam int unsigned      BIT_W    = $clog2(UART_DATA_W);
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(UART_DATA_W - 1);

    rx_state_t        state;
    rx_state_t        state_next;
    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] half_q;
    logic [BIT_W-1:0] bit_cnt;
    logic             stop_sel_q;
    logic             start_det;
    logic             half_hit;
    logic             full_hit;
    logic             sample;

    // Falling edge only; divisors too small to time a bit never start a frame.
    assign start_det = (state == IDLE) && rx_d && !rx_s
                       && (baud_divisor >= DIV_W'(UART_MIN_DIV));
    assign half_hit  = (cnt == half_q - DIV_W'(1));
    assign full_hit  = (cnt == div_q - DIV_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_det) state_next = START;
            START:   if (half_hit) state_next = rx_s ? IDLE : DATA;
            DATA:    if (full_hit && (bit_cnt == LAST_BIT)) state_next = PARITY;
            PARITY:  if (full_hit) state_next = STOP1;
            STOP1:   if (full_hit) state_next = stop_sel_q ? STOP2 : IDLE;
            STOP2:   if (full_hit) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sample      = 1'b0;
        shift_en_c  = 1'b0;
        parity_en_c = 1'b0;
        stop1_en_c  = 1'b0;
        stop2_en_c  = 1'b0;
        done_c      = 1'b0;
        case (state)
            START:  sample = half_hit;
            DATA: begin
                sample     = full_hit;
                shift_en_c = full_hit;
            end
            PARITY: begin
                sample      = full_hit;
                parity_en_c = full_hit;
            end
            STOP1: begin
                sample     = full_hit;
                stop1_en_c = full_hit;
                done_c     = full_hit && !stop_sel_q;
            end
            STOP2: begin
                sample     = full_hit;
                stop2_en_c = full_hit;
                done_c     = full_hit;
            end
            default: ;
        endcase
    end

    // Frame config is frozen at start detect so mid-frame changes are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            div_q        <= '0;
            half_q       <= '0;
            stop_sel_q   <= 1'b0;
            parity_sel_q <= 1'b0;
        end else if (start_det) begin
            cnt          <= '0;
            bit_cnt      <= '0;
            div_q        <= baud_divisor;
            half_q       <= baud_divisor >> 1;
            stop_sel_q   <= stop_sel;
            parity_sel_q <= parity_sel;
        end else if (state != IDLE) begin
            cnt <= sample ? '0 : cnt + DIV_W'(1);
            if (shift_en_c) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// UART receiver: line synchronizer, data shift register, error flags and result registers.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int unsigned DATA_W = UART_DATA_W,
    parameter int unsigned DIV_W  = UART_DIV_W
) (
    input  logic     clk,
    input  logic     reset,
    uart_rx_if.slave bus
);

    logic              sync_q;
    logic              rx_s;
    logic              rx_d;
    logic [DATA_W-1:0] shift_q;
    logic              perr_q;
    logic              ferr_q;
    logic              ferr_now_c;
    rx_result_t        result_q;
    logic              valid_q;
    logic              busy_q;
    logic              parity_sel_q;
    logic              shift_en_c;
    logic              parity_en_c;
    logic              stop1_en_c;
    logic              stop2_en_c;
    logic              done_c;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 1'b1;
            rx_s   <= 1'b1;
            rx_d   <= 1'b1;
        end else begin
            sync_q <= bus.rx_in;
            rx_s   <= sync_q;
            rx_d   <= rx_s;
        end
    end

    uart_rx_controller #(
        .DIV_W (DIV_W)
    ) u_ctrl (
        .clk          (clk),
        .reset        (reset),
        .rx_s         (rx_s),
        .rx_d         (rx_d),
        .parity_sel   (bus.parity_sel),
        .stop_sel     (bus.stop_sel),
        .baud_divisor (bus.baud_divisor),
        .parity_sel_q (parity_sel_q),
        .busy         (busy_q),
        .shift_en_c   (shift_en_c),
        .parity_en_c  (parity_en_c),
        .stop1_en_c   (stop1_en_c),
        .stop2_en_c   (stop2_en_c),
        .done_c       (done_c)
    );

    // LSB arrives first, so shift in at the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q <= '0;
        end else if (shift_en_c) begin
            shift_q <= {rx_s, shift_q[DATA_W-1:1]};
        end
    end

    // Includes the stop bit being sampled this cycle so the result sees it.
    assign ferr_now_c = stop2_en_c ? (ferr_q | ~rx_s) : ~rx_s;

    always_ff @(posedge clk) begin
        if (reset) begin
            perr_q <= 1'b0;
            ferr_q <= 1'b0;
        end else begin
            if (parity_en_c) begin
                perr_q <= ((^shift_q) ^ rx_s) != parity_sel_q;
            end
            if (stop1_en_c || stop2_en_c) begin
                ferr_q <= ferr_now_c;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            result_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            valid_q <= done_c;
            if (done_c) begin
                result_q.data       <= UART_DATA_W'(shift_q);
                result_q.parity_err <= perr_q;
                result_q.frame_err  <= ferr_now_c;
            end
        end
    end

    assign bus.data_out   = DATA_W'(result_q.data);
    assign bus.valid_out  = valid_q;
    assign bus.parity_err = result_q.parity_err;
    assign bus.frame_err  = result_q.frame_err;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Directed bench for uart_rx_top: frames driven bit by bit at divisor 16.
module tb_uart_rx_top;
    import uart_pkg::*;

    localparam int unsigned DIV = 16;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if bus_if ();

    uart_rx_top dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int unsigned cyc      = 0;
    int unsigned fall_cyc = 0;
    int unsigned v_count  = 0;
    int unsigned v_cyc    = 0;
    int unsigned v0       = 0;
    int          n_checks = 0;
    int          n_fail   = 0;
    logic [9:0]  cap_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Records every valid pulse with its cycle and {frame_err, parity_err, data}.
    always @(negedge clk) begin
        if (bus_if.valid_out === 1'b1) begin
            v_count <= v_count + 1;
            v_cyc   <= cyc;
            cap_q.push_back({bus_if.frame_err, bus_if.parity_err, bus_if.data_out});
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bus_if.rx_in = b;
        step(DIV);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit,
                              input logic s1, input logic s2, input logic two);
        fall_cyc = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        bus_if.rx_in = 1'b1;
    endtask

    task automatic check_result(input string tag, input logic [7:0] d,
                                input logic perr, input logic ferr);
        check_eq({tag, "_data"}, 32'(bus_if.data_out), 32'(d));
        check_eq({tag, "_perr"}, 32'(bus_if.parity_err), 32'(perr));
        check_eq({tag, "_ferr"}, 32'(bus_if.frame_err), 32'(ferr));
        check_eq({tag, "_busy"}, 32'(bus_if.busy), 0);
    endtask

    initial begin
        reset               = 1'b1;
        bus_if.rx_in        = 1'b1;
        bus_if.parity_sel   = PARITY_EVEN;
        bus_if.stop_sel     = STOP_ONE;
        bus_if.baud_divisor = 12'(DIV);
        step(3);
        reset = 1'b0;
        step(2);
        check_eq("rst_valid", 32'(bus_if.valid_out), 0);
        check_result("rst", 8'h00, 1'b0, 1'b0);

        // 0xA5, even parity, one stop bit
        v0 = v_count;
        send_frame(8'hA5, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t1_count", v_count - v0, 1);
        check_eq("t1_latency", v_cyc - fall_cyc, 171);
        check_eq("t1_valid_low", 32'(bus_if.valid_out), 0);
        check_result("t1", 8'hA5, 1'b0, 1'b0);

        // 0x00 with odd parity selected but parity bit 0
        bus_if.parity_sel = PARITY_ODD;
        v0 = v_count;
        send_frame(8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t2_count", v_count - v0, 1);
        check_result("t2", 8'h00, 1'b1, 1'b0);

        // 0x3C, two stop bits, second stop bit low
        bus_if.parity_sel = PARITY_EVEN;
        bus_if.stop_sel   = STOP_TWO;
        v0 = v_count;
        send_frame(8'h3C, 1'b0, 1'b1, 1'b0, 1'b1);
        check_eq("t3_count", v_count - v0, 1);
        check_eq("t3_latency", v_cyc - fall_cyc, 187);
        check_result("t3", 8'h3C, 1'b0, 1'b1);
        step(20);
        check_eq("t3_no_retrigger", v_count - v0, 1);
        check_eq("t3_idle", 32'(bus_if.busy), 0);

        // 4-clock glitch rejected at the start-bit midpoint
        bus_if.stop_sel = STOP_ONE;
        v0 = v_count;
        fall_cyc = cyc;
        bus_if.rx_in = 1'b0;
        step(4);
        bus_if.rx_in = 1'b1;
        step(1);
        check_eq("t4_busy_hi", 32'(bus_if.busy), 1);
        step(6);
        check_eq("t4_busy_lo", 32'(bus_if.busy), 0);
        check_eq("t4_no_valid", v_count - v0, 0);
        send_frame(8'h81, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t4_count", v_count - v0, 1);
        check_result("t4", 8'h81, 1'b0, 1'b0);

        // Divisor below minimum: falling edge ignored
        bus_if.baud_divisor = 12'd3;
        v0 = v_count;
        step(1);
        bus_if.rx_in = 1'b0;
        step(6);
        check_eq("div3_busy_a", 32'(bus_if.busy), 0);
        bus_if.rx_in = 1'b1;
        step(6);
        check_eq("div3_busy_b", 32'(bus_if.busy), 0);
        check_eq("div3_no_valid", v_count - v0, 0);
        bus_if.baud_divisor = 12'(DIV);
        step(2);

        // Reset during data bit 3 of 0xFF
        v0 = v_count;
        fall_cyc = cyc;
        bus_if.rx_in = 1'b0;
        step(DIV);
        bus_if.rx_in = 1'b1;
        step(3 * DIV + DIV / 2);
        check_eq("t5_busy_mid", 32'(bus_if.busy), 1);
        reset = 1'b1;
        step(1);
        check_eq("t5_rst_valid", 32'(bus_if.valid_out), 0);
        check_result("t5_rst", 8'h00, 1'b0, 1'b0);
        reset = 1'b0;
        step(120);
        check_eq("t5_no_valid", v_count - v0, 0);
        check_eq("t5_idle", 32'(bus_if.busy), 0);
        send_frame(8'h5A, 1'b0, 1'b1, 1'b1, 1'b0);
        check_eq("t5_count", v_count - v0, 1);
        check_result("t5", 8'h5A, 1'b0, 1'b0);

        // Back-to-back 0x55, 0xAA, odd parity, two stop bits
        bus_if.parity_sel = PARITY_ODD;
        bus_if.stop_sel   = STOP_TWO;
        cap_q.delete();
        v0 = v_count;
        send_frame(8'h55, 1'b1, 1'b1, 1'b1, 1'b1);
        send_frame(8'hAA, 1'b1, 1'b1, 1'b1, 1'b1);
        step(2);
        check_eq("t6_count", v_count - v0, 2);
        check_eq("t6_latency", v_cyc - fall_cyc, 187);
        check_eq("t6_captured", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            check_eq("t6_first", 32'(cap_q[0]), 32'h055);
            check_eq("t6_second", 32'(cap_q[1]), 32'h0AA);
        end
        check_result("t6", 8'hAA, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
